// File: rtl/fft_frame_loader.sv
// fft_frame_loader: captures one 2048-sample ADC frame into a local buffer,
// programs the FFT core (forward, fixed scaling), pulses start, then replays
// the buffer to the core as it walks xn_index and waits for the core's done.
module fft_frame_loader #(
  parameter int          DATA_W    = 10,
  parameter int          ADDR_W    = 11,
  parameter logic [11:0] SCALE_SCH = 12'hAAA,
  parameter int          RD_LAT    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              arm,
  input  logic              rfd,
  input  logic [ADDR_W-1:0] xn_index,
  input  logic              busy,
  input  logic              done,
  output logic              start,
  output logic              fwd_inv,
  output logic              fwd_inv_we,
  output logic [11:0]       scale_sch,
  output logic              scale_sch_we,
  output logic [DATA_W-1:0] xn_re,
  output logic [DATA_W-1:0] xn_im,
  output logic              capturing,
  output logic              fft_active,
  output logic [15:0]       frame_cnt,
  output logic              arm_err
);

  localparam int               DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_CAPTURE,
    S_START,
    S_LOAD,
    S_WAIT_DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_addr;
  logic                rfd_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_pipe [RD_LAT];

  // busy is status only; the sequencing relies on rfd and done instead
  logic unused_busy;
  assign unused_busy = busy;

  assign fwd_inv   = 1'b1;
  assign scale_sch = SCALE_SCH;
  assign xn_im     = '0;
  assign xn_re     = rd_pipe[RD_LAT-1];

  // Frame sequencer: owns every control output as a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      start        <= 1'b0;
      fwd_inv_we   <= 1'b0;
      scale_sch_we <= 1'b0;
      capturing    <= 1'b0;
      fft_active   <= 1'b0;
      wr_addr      <= '0;
      rfd_q        <= 1'b0;
      frame_cnt    <= '0;
      arm_err      <= 1'b0;
    end else begin
      start        <= 1'b0;
      fwd_inv_we   <= 1'b0;
      scale_sch_we <= 1'b0;
      if (arm && state != S_IDLE) arm_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (arm) begin
            state        <= S_CONFIG;
            fwd_inv_we   <= 1'b1;
            scale_sch_we <= 1'b1;
          end
        end
        S_CONFIG: begin
          state     <= S_CAPTURE;
          wr_addr   <= '0;
          capturing <= 1'b1;
        end
        S_CAPTURE: begin
          if (adc_valid) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            if (wr_addr == LAST_ADDR) begin
              state      <= S_START;
              start      <= 1'b1;
              capturing  <= 1'b0;
              fft_active <= 1'b1;
            end
          end
        end
        S_START: begin
          state <= S_LOAD;
          rfd_q <= 1'b0;
        end
        S_LOAD: begin
          // Leave only on a falling rfd, which implies rfd was seen high here
          rfd_q <= rfd;
          if (rfd_q && !rfd) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (done) begin
            state      <= S_IDLE;
            fft_active <= 1'b0;
            frame_cnt  <= frame_cnt + 16'd1;
          end
        end
        default: begin
          state      <= S_IDLE;
          capturing  <= 1'b0;
          fft_active <= 1'b0;
        end
      endcase
    end
  end

  // Frame buffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE && adc_valid) mem[wr_addr] <= adc_data;
  end

  // Registered buffer read followed by a delay line so xn_re lands RD_LAT cycles after xn_index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= mem[xn_index];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: directed frames with a behavioural buffer model
// and a core model that walks xn_index and expects the stored samples back.
module tb_fft_frame_loader;

  localparam int RD_LAT = 3;

  logic        clk;
  logic        rst_n;
  logic [9:0]  adc_data;
  logic        adc_valid;
  logic        arm;
  logic        rfd;
  logic [10:0] xn_index;
  logic        busy;
  logic        done;
  logic        start;
  logic        fwd_inv;
  logic        fwd_inv_we;
  logic [11:0] scale_sch;
  logic        scale_sch_we;
  logic [9:0]  xn_re;
  logic [9:0]  xn_im;
  logic        capturing;
  logic        fft_active;
  logic [15:0] frame_cnt;
  logic        arm_err;

  fft_frame_loader #(
    .DATA_W(10), .ADDR_W(11), .SCALE_SCH(12'hAAA), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .arm(arm), .rfd(rfd), .xn_index(xn_index), .busy(busy), .done(done),
    .start(start), .fwd_inv(fwd_inv), .fwd_inv_we(fwd_inv_we),
    .scale_sch(scale_sch), .scale_sch_we(scale_sch_we), .xn_re(xn_re),
    .xn_im(xn_im), .capturing(capturing), .fft_active(fft_active),
    .frame_cnt(frame_cnt), .arm_err(arm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [9:0] val;
  } exp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         pcnt    = 0;
  int         start_cnt = 0;
  logic [9:0] model_mem [2048];
  exp_t       q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] pat(input int f, input int i);
    int v;
    case (f)
      0:       v = i;
      1:       v = i * 37 + (i >> 10) * 5;
      2:       v = ((i * 11) ^ (i >> 3)) + (i >> 10) * 300;
      default: v = 2047 - i + (i >> 10) * 17;
    endcase
    return v[9:0];
  endfunction

  always @(posedge clk) pcnt <= pcnt + 1;

  // Compare process: xn_re against the buffer model, constant outputs, start counting
  always @(negedge clk) begin
    if (rst_n) begin
      if (start) start_cnt++;
      if (q.size() > 0 && q[0].due == pcnt) begin
        exp_t e;
        e = q.pop_front();
        check("xn_re", {22'd0, xn_re}, {22'd0, e.val});
      end
      if (pcnt % 256 == 0) begin
        check("const_outs", {7'd0, fwd_inv, xn_im, scale_sch}, {7'd0, 1'b1, 10'd0, 12'hAAA});
      end
    end
  end

  task automatic chk_reset();
    check("rst_start", start, 0);
    check("rst_fwd_inv_we", fwd_inv_we, 0);
    check("rst_scale_sch_we", scale_sch_we, 0);
    check("rst_xn_re", xn_re, 0);
    check("rst_capturing", capturing, 0);
    check("rst_fft_active", fft_active, 0);
    check("rst_arm_err", arm_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_fwd_inv", fwd_inv, 1);
    check("rst_xn_im", xn_im, 0);
    check("rst_scale_sch", scale_sch, 12'hAAA);
  endtask

  task automatic do_arm();
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
    @(negedge clk);
    check("cfg_fwd_inv_we", fwd_inv_we, 1);
    check("cfg_scale_sch_we", scale_sch_we, 1);
    check("cfg_scale_sch", scale_sch, 12'hAAA);
    check("cfg_fwd_inv", fwd_inv, 1);
    check("cfg_capturing", capturing, 0);
    @(posedge clk); #1;
  endtask

  // Sends n samples of pattern f; only a complete frame updates the model
  task automatic capture(input int f, input bit gapped, input int n);
    for (int i = 0; i < n; i++) begin
      adc_data  = pat(f, i);
      adc_valid = 1'b1;
      if (n == 2048) model_mem[i] = pat(f, i);
      @(negedge clk);
      if (i == 0) begin
        check("cap_capturing", capturing, 1);
        check("cap_strobes_off", {fwd_inv_we, scale_sch_we}, 0);
      end
      if (i == 2047) check("start_early", start, 0);
      @(posedge clk); #1;
      if (gapped && i != n - 1) begin
        adc_valid = 1'b0;
        adc_data  = ~pat(f, i);
        done      = (i == 500);
        @(posedge clk); #1;
        done = 1'b0;
      end
    end
    adc_valid = 1'b1;
    adc_data  = 10'h2AA;
  endtask

  task automatic post_start();
    @(negedge clk);
    check("start_pulse", start, 1);
    check("start_capturing", capturing, 0);
    check("start_fft_active", fft_active, 1);
  endtask

  // Core model: walks xn_index in the given order while rfd is high
  task automatic run_core(input int mode, input bit arm_mid, input bit lit_chk);
    exp_t e;
    int   idx;
    @(posedge clk); #1;
    rfd = 1'b1;
    for (int j = 0; j < 2048; j++) begin
      idx = (mode == 1) ? (j * 3) % 2048 : ((mode == 2) ? 2047 - j : j);
      xn_index = idx[10:0];
      e.due = pcnt + RD_LAT;
      e.val = model_mem[idx];
      q.push_back(e);
      arm = arm_mid && (j == 1000);
      if (lit_chk && j == 1033) check("xn_re_lit_1030", xn_re, 10'd6);
      if (lit_chk && j == 2047) check("xn_re_lit_2044", xn_re, 10'h3FC);
      @(posedge clk); #1;
    end
    arm      = 1'b0;
    rfd      = 1'b0;
    xn_index = '0;
    @(negedge clk);
    check("load_fft_active", fft_active, 1);
    repeat (RD_LAT + 2) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
  endtask

  task automatic finish_frame(input int exp_cnt, input bit exp_err, input int exp_starts);
    @(negedge clk);
    check("wait_fft_active", fft_active, 1);
    check("wait_frame_cnt", frame_cnt, exp_cnt - 1);
    check("start_count", start_cnt, exp_starts);
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    @(negedge clk);
    check("done_frame_cnt", frame_cnt, exp_cnt);
    check("done_fft_active", fft_active, 0);
    check("done_arm_err", arm_err, exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n = 1'b1; adc_data = '0; adc_valid = 1'b0; arm = 1'b0;
    rfd = 1'b0; xn_index = '0; busy = 1'b0; done = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    adc_valid = 1'b1;
    adc_data  = 10'h2AA;

    // Frame 1: continuous ramp, core walks 0..2047
    s = start_cnt;
    do_arm();
    capture(0, 1'b0, 2048);
    check("model_pin_1030", model_mem[1030], 10'd6);
    check("model_pin_2047", model_mem[2047], 10'h3FF);
    post_start();
    busy = 1'b1;
    run_core(0, 1'b0, 1'b1);
    finish_frame(1, 1'b0, s + 1);
    busy = 1'b0;
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    @(negedge clk);
    check("idle_done_ignored", frame_cnt, 16'd1);

    // Frame 2: gapped input, stray done during capture, strided read order
    s = start_cnt;
    do_arm();
    capture(1, 1'b1, 2048);
    post_start();
    run_core(1, 1'b0, 1'b0);
    finish_frame(2, 1'b0, s + 1);

    // Frame 3: arm during LOAD flags arm_err but the frame completes
    s = start_cnt;
    do_arm();
    capture(2, 1'b0, 2048);
    post_start();
    run_core(2, 1'b1, 1'b0);
    check("arm_err_set", arm_err, 1);
    finish_frame(3, 1'b1, s + 1);

    // Frame 4: reset after 1000 samples aborts the frame
    do_arm();
    capture(3, 1'b0, 1000);
    #3 rst_n = 1'b0;
    #1 chk_reset();
    s = start_cnt;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_rst_capturing", capturing, 0);
    check("post_rst_no_start", start_cnt, s);

    // Frame 5: fresh full capture after the abort
    do_arm();
    capture(3, 1'b0, 2048);
    post_start();
    run_core(2, 1'b0, 1'b0);
    finish_frame(1, 1'b0, s + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Upstream feeder for the 2048-point FFT core. Captures one frame of 10-bit ADC samples into an internal 2048×10 buffer. It then programs the core (forward transform, fixed scaling schedule), pulses `start`, and serves `xn_re` from the buffer as the core walks `xn_index`. It holds off until the core reports `done`, then returns to idle for the next armed frame.

## Interface
Parameters:
- `DATA_W`, 10, sample width (matches core `xn_re`/`xn_im`)
- `ADDR_W`, 11, log2 of frame length (2048 points)
- `SCALE_SCH`, 12'hAAA, scaling schedule written to core
- `RD_LAT`, 3, cycles from `xn_index` to the matching `xn_re` expected by core (range 1..4)

Ports:
- `clk`  in  1  sole clock, all logic rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `adc_data`  in  DATA_W  ADC sample, two's complement
- `adc_valid`  in  1  `adc_data` valid this cycle
- `arm`  in  1  request capture+transform of next frame (pulse or level)
- `rfd`  in  1  core ready-for-data
- `xn_index`  in  ADDR_W  core input index
- `busy`  in  1  core busy (status only)
- `done`  in  1  core transform complete pulse
- `start`  out  1  one-cycle start pulse to core
- `fwd_inv`  out  1  transform direction, constant 1 (forward)
- `fwd_inv_we`  out  1  direction write strobe
- `scale_sch`  out  12  constant `SCALE_SCH`
- `scale_sch_we`  out  1  schedule write strobe
- `xn_re`  out  DATA_W  buffered sample for core
- `xn_im`  out  DATA_W  constant 0
- `capturing`  out  1  high in CAPTURE
- `fft_active`  out  1  high in START, LOAD, WAIT_DONE
- `frame_cnt`  out  16  completed frames, wraps at 65535→0
- `arm_err`  out  1  sticky: `arm` seen outside IDLE

## Operation
- States: IDLE, CONFIG, CAPTURE, START, LOAD, WAIT_DONE.
- IDLE: `arm`=1 → CONFIG.
- CONFIG (exactly 1 cycle): `fwd_inv_we`=`scale_sch_we`=1 → CAPTURE. Write pointer `wr_addr` cleared.
- CAPTURE: each `adc_valid` cycle writes `adc_data` to `mem[wr_addr]` and increments `wr_addr`. A gap (`adc_valid`=0) holds `wr_addr`. The write at `wr_addr`=2047 → START. Samples while not in CAPTURE are discarded.
- START (1 cycle): `start`=1 → LOAD.
- LOAD: buffer read address = `xn_index`. `xn_re` at cycle t+`RD_LAT` = `mem[xn_index(t)]`, implemented as registered RAM read plus a delay pipe. Exit to WAIT_DONE on the first rfd falling edge (`rfd`=1 last cycle, 0 now). Until `rfd` has been seen high, remain in LOAD.
- WAIT_DONE: `done`=1 → IDLE, `frame_cnt` += 1.
- `arm` in any state except IDLE sets `arm_err`. Only reset clears it.
- `busy` is not used for sequencing.
- No arithmetic on sample data; values pass bit-exact.

## Timing
- Reset (async assert, synchronous-safe release): state=IDLE. Outputs `start`, `fwd_inv_we`, `scale_sch_we`, `xn_re`, `capturing`, `fft_active`, `arm_err`=0. `frame_cnt`=0. `fwd_inv`=1. `xn_im`=0. `scale_sch`=`SCALE_SCH`. Buffer contents are not cleared.
- Reset mid-frame: abort immediately. No `start` is issued afterward. The next frame requires a new `arm`.
- `arm` at edge k → CONFIG strobes at cycle k+1 → CAPTURE from k+2.
- With continuous `adc_valid` from k+2, the last write is at k+2049, `start`=1 at k+2050, and LOAD begins at k+2051.
- All control outputs are registered, with no combinational input→output paths.
- `done` in any state other than WAIT_DONE is ignored.

## Test plan
- Reset values: assert `rst_n`=0 mid-cycle → all outputs at listed reset values within the same cycle; `frame_cnt`=0.
- Config: `arm` pulse → exactly one cycle with `fwd_inv_we`=`scale_sch_we`=1, `scale_sch`=12'hAAA, `fwd_inv`=1, then `capturing`=1.
- Ramp frame: `adc_data`=i[9:0] for i=0..2047, continuous → `start` 1 cycle after i=2047. A core model walking `xn_index` 0..2047 sees `xn_re`=index[9:0] exactly 3 cycles later. `done` → `frame_cnt`=1, IDLE.
- Gapped input: `adc_valid` toggling 1/0 → still exactly 2048 samples stored in order, and `start` only after the 2048th valid.
- Ignored arm: `arm` during LOAD → `arm_err`=1, frame unaffected, `frame_cnt` increments normally.
- Reset mid-capture after 1000 samples, then release and `arm` → fresh 2048-sample capture. No `start` before the new frame completes.
